serial_sub_32bit: RTL
=====================

SERIAL_SUB_32BIT -- requirements
Module: serial_sub_32bit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH mod DIGIT SHALL be 0.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands are offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts operands.
REQ-007 SHALL have port A, input, WIDTH: minuend.
REQ-008 SHALL have port B, input, WIDTH: subtrahend.
REQ-009 SHALL have port bin, input, 1: borrow-in.
REQ-010 SHALL have port out_valid, output, 1: the result is presented.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-012 SHALL have port diff, output, WIDTH: A - B - bin modulo 2^WIDTH.
REQ-013 SHALL have port bout, output, 1: borrow-out; 1 iff A < B + bin as unsigned values.
REQ-014 SHALL have port ovf, output, 1: signed overflow, equal to borrow into MSB XOR bout.
REQ-015 SHALL have port zero, output, 1: diff == 0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; when in_valid=1, SHALL capture A, B and bin into shift registers, clear the digit counter, and go to RUN.
REQ-018 RUN: in_ready=0, out_valid=0; each cycle SHALL subtract the low DIGIT bits of the shifted operands with the running borrow, shift the result digit into diff from the MSB side, and increment the counter.
REQ-019 RUN SHALL last exactly WIDTH/DIGIT cycles (8 at default), then go to DONE; out_valid SHALL rise on the 8th edge after the accepting edge.
REQ-020 DONE: out_valid=1, in_ready=0; diff, bout, ovf and zero SHALL hold stable until out_ready=1, and the next edge SHALL go to IDLE.
REQ-021 in_valid in RUN or DONE SHALL be ignored; operand changes after the accepting edge SHALL not affect the result.
REQ-022 out_ready outside DONE SHALL be ignored.
REQ-023 Counter wrap: the counter SHALL be sized ceil(log2(WIDTH/DIGIT))+1 bits and SHALL never wrap within an operation.
REQ-024 zero and ovf SHALL be registered and valid exactly when out_valid=1.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, zero=0, and clear the counter and borrow.
REQ-026 Reset during RUN or DONE SHALL abandon the operation; no out_valid for it ever appears.
REQ-027 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the defaults WIDTH=32 and DIGIT=4.
REQ-029 A combinational sub-module sub_digit (DIGIT-bit ripple-borrow subtractor: a, b, bi -> d, bo, plus borrow into its MSB) SHALL be instantiated once.

Verification
REQ-030 A=128, B=64, bin=1 -> diff=63, bout=0, ovf=0, zero=0; out_valid 8 cycles after acceptance.
REQ-031 A=0, B=1, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0.
REQ-032 A=0x80000000, B=1, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1; A=5, B=5 -> zero=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no new operand captured; release -> IDLE on the next edge.
REQ-034 Assert rst_n=0 on the 4th cycle of RUN -> outputs reset immediately, no out_valid; a new operation then completes correctly.
REQ-035 Random compare: 1000 random A/B/bin with random out_ready stalls -> every result matches the reference model.

Source files
------------

// File: rtl/serial_sub_32bit_pkg.sv
// serial_sub_32bit_pkg: shared FSM encoding and default operand/digit widths.
package serial_sub_32bit_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 4;
endpackage

// File: rtl/sub_digit.sv
// sub_digit: W-bit subtractor a - b - bi with borrow-out and the borrow into the MSB.
module sub_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo,
    output logic         bm
);
    assign {bo, d} = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
    // The MSB sum bit is a^b^borrow_in, so the incoming borrow falls out by XOR.
    assign bm = d[W-1] ^ a[W-1] ^ b[W-1];
endmodule

// File: rtl/serial_sub_32bit.sv
// serial_sub_32bit: digit-serial A - B - bin, DIGIT bits per cycle, valid/ready on both sides.
module serial_sub_32bit
    import serial_sub_32bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW = $clog2(STEPS) + 1;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic br_q, br_d, bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [DIGIT-1:0] dig_d;
    logic dig_bo, dig_bm;

    sub_digit #(.W(DIGIT)) u_sub_digit (
        .a (a_q[DIGIT-1:0]),
        .b (b_q[DIGIT-1:0]),
        .bi(br_q),
        .d (dig_d),
        .bo(dig_bo),
        .bm(dig_bm)
    );

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        br_d = br_q;
        cnt_d = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        ovf_d = ovf_q;
        zero_d = zero_q;
        if (state_q == IDLE && in_valid) begin
            state_d = RUN;
            a_d = A;
            b_d = B;
            br_d = bin;
            cnt_d = '0;
            diff_d = '0;
            bout_d = 1'b0;
            ovf_d = 1'b0;
            zero_d = 1'b0;
        end else if (state_q == RUN) begin
            a_d = a_q >> DIGIT;
            b_d = b_q >> DIGIT;
            br_d = dig_bo;
            cnt_d = cnt_q + 1'b1;
            // Result digits enter at the top so the last digit lands in the MSBs.
            diff_d = WIDTH'({dig_d, diff_q} >> DIGIT);
            if (cnt_q == CW'(STEPS - 1)) begin
                state_d = DONE;
                bout_d = dig_bo;
                ovf_d = dig_bo ^ dig_bm;
                zero_d = diff_d == '0;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            br_q <= 1'b0;
            cnt_q <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            br_q <= br_d;
            cnt_q <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf = ovf_q;
    assign zero = zero_q;
endmodule
